// File: rtl/mci_line_responder_pkg.sv
// Shared MCI types: request/response structs, line geometry and responder state encoding.
package memory_controller_interface;

  localparam int MCI_DATA_LENGTH      = 128;
  localparam int MCI_ADDR_LENGTH      = 32;
  // Byte offset bits within a line; these address bits never select a word.
  localparam int MCI_LINE_OFFSET_BITS = 4;

  typedef struct packed {
    logic [MCI_ADDR_LENGTH-1:0] addr;
    logic [MCI_DATA_LENGTH-1:0] data;
    logic                       rw;
    logic                       valid;
  } mci_request_t;

  typedef struct packed {
    logic                       ready;
    logic [MCI_DATA_LENGTH-1:0] data;
  } mci_response_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WAIT  = 3'd1,
    XFER  = 3'd2,
    DRAIN = 3'd3,
    RESP  = 3'd4
  } mci_state_t;

endpackage

// File: rtl/mci_line_responder_word_store.sv
// Single-port word RAM with one-cycle registered read; drop-in replaceable by a hard macro.
module mci_word_store #(
  parameter int    WORD_LENGTH = 32,
  parameter int    DEPTH_WORDS = 16384,
  parameter string INIT_FILE   = "",
  parameter int    AW          = $clog2(DEPTH_WORDS)
) (
  input  logic                   i_clk,
  input  logic                   i_we,
  input  logic [AW-1:0]          i_addr,
  input  logic [WORD_LENGTH-1:0] i_wdata,
  output logic [WORD_LENGTH-1:0] o_rdata
);

  logic [WORD_LENGTH-1:0] r_mem [DEPTH_WORDS];
  logic [WORD_LENGTH-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
    r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mci_line_responder.sv
// Memory-side MCI endpoint: latches a line request, waits the access latency,
// streams the line word-by-word through the store, then pulses ready for one cycle.
module mci_line_responder
  import memory_controller_interface::*;
#(
  parameter int    ADDR_LENGTH    = 32,
  parameter int    WORD_LENGTH    = 32,
  parameter int    DEPTH_WORDS    = 16384,
  parameter int    ACCESS_LATENCY = 2,
  parameter string INIT_FILE      = ""
) (
  input  logic          clk,
  input  logic          rst,
  input  mci_request_t  mem_req,
  output mci_response_t mem_res,
  output logic          protocol_err,
  output mci_state_t    o_dbg_state
);

  localparam int BEATS  = MCI_DATA_LENGTH / WORD_LENGTH;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int AW     = $clog2(DEPTH_WORDS);
  localparam int LAT_W  = (ACCESS_LATENCY > 1) ? $clog2(ACCESS_LATENCY) : 1;

  localparam logic [LAT_W-1:0]  LAT_LOAD  = LAT_W'((ACCESS_LATENCY > 0) ? ACCESS_LATENCY - 1 : 0);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam mci_state_t        START_ST  = (ACCESS_LATENCY == 0) ? XFER : WAIT;

  // Handshake: mem_req.valid is a one-cycle pulse with no backpressure. It is
  // accepted only in IDLE or RESP; in any other state it is dropped and the
  // sticky protocol_err is raised. mem_res.ready is high for exactly the one
  // RESP cycle and depends only on registered state.

  mci_state_t                 r_state;
  mci_state_t                 w_next;
  logic [LAT_W-1:0]           r_wait_cnt;
  logic [BEAT_W-1:0]          r_beat;
  logic [ADDR_LENGTH-1:0]     r_addr;
  logic [MCI_DATA_LENGTH-1:0] r_wdata;
  logic                       r_rw;
  logic [MCI_DATA_LENGTH-1:0] r_line;
  logic                       r_perr;

  logic                   w_accept;
  logic                   w_busy_hit;
  logic                   w_last_beat;
  logic                   w_capture;
  logic [BEAT_W-1:0]      w_cap_idx;
  logic                   w_we;
  logic [AW-1:0]          w_ram_addr;
  logic [WORD_LENGTH-1:0] w_ram_wdata;
  logic [WORD_LENGTH-1:0] w_ram_rdata;

  assign w_accept    = mem_req.valid && ((r_state == IDLE) || (r_state == RESP));
  assign w_busy_hit  = mem_req.valid && !((r_state == IDLE) || (r_state == RESP));
  assign w_last_beat = (r_beat == LAST_BEAT);

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  if (w_accept) w_next = START_ST;
      WAIT:  if (r_wait_cnt == '0) w_next = XFER;
      XFER:  if (w_last_beat) w_next = r_rw ? RESP : DRAIN;
      DRAIN: w_next = RESP;
      RESP:  w_next = w_accept ? START_ST : IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Read data trails its address by one cycle, so beat k lands while beat k+1
  // (or DRAIN, for the last beat) is being issued.
  assign w_capture = !r_rw && (((r_state == XFER) && (r_beat != '0)) || (r_state == DRAIN));
  assign w_cap_idx = (r_state == DRAIN) ? LAST_BEAT : (r_beat - 1'b1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_wait_cnt <= '0;
      r_beat     <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rw       <= 1'b0;
      r_line     <= '0;
      r_perr     <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_addr     <= mem_req.addr;
        r_wdata    <= mem_req.data;
        r_rw       <= mem_req.rw;
        r_wait_cnt <= LAT_LOAD;
        r_beat     <= '0;
      end else if ((r_state == WAIT) && (r_wait_cnt != '0)) begin
        r_wait_cnt <= r_wait_cnt - 1'b1;
      end
      if (r_state == XFER) r_beat <= w_last_beat ? '0 : (r_beat + 1'b1);
      if (w_busy_hit) r_perr <= 1'b1;
      if (w_capture) r_line[WORD_LENGTH*w_cap_idx +: WORD_LENGTH] <= w_ram_rdata;
    end
  end

  // Line base = line index * BEATS; truncation to AW bits gives the silent wrap.
  assign w_ram_addr  = AW'(r_addr >> MCI_LINE_OFFSET_BITS) * AW'(BEATS) + AW'(r_beat);
  assign w_we        = (r_state == XFER) && r_rw;
  assign w_ram_wdata = r_wdata[WORD_LENGTH*r_beat +: WORD_LENGTH];

  mci_word_store #(
    .WORD_LENGTH (WORD_LENGTH),
    .DEPTH_WORDS (DEPTH_WORDS),
    .INIT_FILE   (INIT_FILE),
    .AW          (AW)
  ) u_store (
    .i_clk   (clk),
    .i_we    (w_we),
    .i_addr  (w_ram_addr),
    .i_wdata (w_ram_wdata),
    .o_rdata (w_ram_rdata)
  );

  assign mem_res.ready = (r_state == RESP);
  assign mem_res.data  = r_line;
  assign protocol_err  = r_perr;
  assign o_dbg_state   = r_state;

endmodule
